// File: rtl/cam_match_drain.sv
// Drains a multi-hot CAM match vector one hit per cycle, highest index first,
// over a valid/ready handshake; an empty vector yields a single "none" beat.
`ifndef SASA_CAM_len
`define SASA_CAM_len 256
`endif

module cam_match_drain #(
    parameter int CAM_LEN = `SASA_CAM_len,
    parameter int IDX_W   = $clog2(CAM_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CAM_LEN-1:0] in_vector,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [CAM_LEN-1:0] out_onehot,
    output logic               out_none,
    output logic               out_last,
    output logic [IDX_W:0]     beat_cnt
);

    localparam int LEAF_W  = (CAM_LEN < 16) ? CAM_LEN : 16;
    localparam int LEAF_IW = $clog2(LEAF_W);
    localparam int NLEAF   = CAM_LEN / LEAF_W;
    localparam int LEVELS  = $clog2(NLEAF);

    typedef enum logic [1:0] {IDLE, DRAIN, NONE} stateT;

    stateT              state;
    logic [CAM_LEN-1:0] pending;
    logic [IDX_W:0]     beatCnt;

    function automatic logic [LEAF_IW-1:0] leafEnc(input logic [LEAF_W-1:0] s);
        leafEnc = '0;
        for (int b = 0; b < LEAF_W; b++)
            if (s[b]) leafEnc = LEAF_IW'(b);
    endfunction

    // Level 0 holds the 16-bit leaf encoders; each higher level halves the
    // candidate count, preferring the upper child so the highest index wins.
    for (genvar l = 0; l <= LEVELS; l++) begin : lvl
        localparam int N = NLEAF >> l;
        logic [N-1:0]     v;
        logic [IDX_W-1:0] idx [N];
        if (l == 0) begin : leaf
            for (genvar j = 0; j < N; j++) begin : enc
                assign v[j]   = |pending[j*LEAF_W +: LEAF_W];
                assign idx[j] = IDX_W'(j * LEAF_W)
                              | IDX_W'(leafEnc(pending[j*LEAF_W +: LEAF_W]));
            end
        end else begin : node
            for (genvar j = 0; j < N; j++) begin : sel
                assign v[j]   = lvl[l-1].v[2*j] | lvl[l-1].v[2*j+1];
                assign idx[j] = lvl[l-1].v[2*j+1] ? lvl[l-1].idx[2*j+1]
                                                  : lvl[l-1].idx[2*j];
            end
        end
    end

    logic               rootValid;
    logic [IDX_W-1:0]   topIdx;
    logic [CAM_LEN-1:0] topOnehot;
    logic [CAM_LEN-1:0] nextPending;

    assign rootValid   = lvl[LEVELS].v[0];
    assign topIdx      = lvl[LEVELS].idx[0];
    assign topOnehot   = {{(CAM_LEN-1){1'b0}}, 1'b1} << topIdx;
    assign nextPending = pending & ~topOnehot;

    // Handshake flags are forced low for the whole time reset is held.
    assign in_ready   = rst_n && (state == IDLE);
    assign out_valid  = rst_n && (state != IDLE);
    assign out_index  = (state == DRAIN) ? topIdx : '0;
    assign out_onehot = (state == DRAIN && rootValid) ? topOnehot : '0;
    assign out_none   = (state == NONE);
    assign out_last   = (state == NONE) || (state == DRAIN && ~|nextPending);
    assign beat_cnt   = beatCnt;

    // NOTE: all state is updated with non-blocking assignments so every
    // branch sees the pre-edge values; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            beatCnt <= '0;
        end else if (flush) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pending <= in_vector;
                        beatCnt <= '0;
                        state   <= (|in_vector) ? DRAIN : NONE;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        pending <= nextPending;
                        beatCnt <= beatCnt + (IDX_W+1)'(1);
                        if (~|nextPending) state <= IDLE;
                    end
                end
                NONE: begin
                    if (out_ready) begin
                        beatCnt <= (IDX_W+1)'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_match_drain.sv
// Directed, table-driven bench for cam_match_drain: each table row is one
// clock cycle of inputs plus the outputs expected during that cycle.
module tb_cam_match_drain;

    localparam int CAM_LEN = 256;
    localparam int IDX_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n, flush, in_valid, out_ready;
    logic [CAM_LEN-1:0] in_vector;
    logic               in_ready, out_valid, out_none, out_last;
    logic [IDX_W-1:0]   out_index;
    logic [CAM_LEN-1:0] out_onehot;
    logic [IDX_W:0]     beat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cam_match_drain #(.CAM_LEN(CAM_LEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_onehot(out_onehot), .out_none(out_none), .out_last(out_last),
        .beat_cnt(beat_cnt)
    );

    typedef struct {
        logic               rstN;
        logic               flush;
        logic               inValid;
        logic [CAM_LEN-1:0] vec;
        logic               outReady;
        logic               expReady;
        logic               expValid;
        logic               chkData;
        logic [IDX_W-1:0]   expIdx;
        logic               expNone;
        logic               expLast;
        logic [IDX_W:0]     expCnt;
    } rowT;

    rowT rows[$];

    task automatic check(input string name, input logic [CAM_LEN-1:0] act,
                         input logic [CAM_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addRow(input logic rstN, input logic fl, input logic iv,
                          input logic [CAM_LEN-1:0] vec, input logic ordy,
                          input logic eRdy, input logic eVal, input logic chk,
                          input int eIdx, input logic eNone, input logic eLast,
                          input int eCnt);
        rowT r;
        r.rstN = rstN; r.flush = fl; r.inValid = iv; r.vec = vec; r.outReady = ordy;
        r.expReady = eRdy; r.expValid = eVal; r.chkData = chk;
        r.expIdx = IDX_W'(eIdx); r.expNone = eNone; r.expLast = eLast;
        r.expCnt = (IDX_W+1)'(eCnt);
        rows.push_back(r);
    endtask

    // Idle cycle with no new vector offered.
    task automatic idleRow(input int cnt);
        addRow(1, 0, 0, '0, 0, 1, 0, 1, 0, 0, 0, cnt);
    endtask

    // Drain beat expected while nothing new is being offered.
    task automatic beatRow(input logic ordy, input int idx, input logic last, input int cnt);
        addRow(1, 0, 0, '0, ordy, 0, 1, 1, idx, 0, last, cnt);
    endtask

    logic [CAM_LEN-1:0] v1, v2, v4, allOnes;
    logic [CAM_LEN-1:0] exp1h;

    initial begin
        v1 = '0; v1[255] = 1'b1; v1[130] = 1'b1; v1[17] = 1'b1; v1[0] = 1'b1;
        v2 = '0; v2[200] = 1'b1; v2[5] = 1'b1;
        v4 = '0; v4[100] = 1'b1; v4[50] = 1'b1; v4[10] = 1'b1;
        allOnes = '1;

        // Released from reset
        idleRow(0);
        // Multi-hit {255,130,17,0} at full throughput
        addRow(1, 0, 1, v1, 1, 1, 0, 1, 0, 0, 0, 0);
        beatRow(1, 255, 0, 0);
        beatRow(1, 130, 0, 1);
        beatRow(1, 17, 0, 2);
        beatRow(1, 0, 1, 3);
        idleRow(4);
        // Backpressure {200,5}, out_ready 0,1,0,0,1; a competing vector is ignored
        addRow(1, 0, 1, v2, 0, 1, 0, 1, 0, 0, 0, 4);
        addRow(1, 0, 1, allOnes, 0, 0, 1, 1, 200, 0, 0, 0);
        addRow(1, 0, 1, allOnes, 1, 0, 1, 1, 200, 0, 0, 0);
        addRow(1, 0, 1, allOnes, 0, 0, 1, 1, 5, 0, 1, 1);
        addRow(1, 0, 1, allOnes, 0, 0, 1, 1, 5, 0, 1, 1);
        addRow(1, 0, 1, allOnes, 1, 0, 1, 1, 5, 0, 1, 1);
        idleRow(2);
        // Empty vector gives a single none beat
        addRow(1, 0, 1, '0, 0, 1, 0, 1, 0, 0, 0, 2);
        addRow(1, 0, 0, '0, 0, 0, 1, 1, 0, 1, 1, 0);
        addRow(1, 0, 0, '0, 1, 0, 1, 1, 0, 1, 1, 0);
        idleRow(1);
        // Flush on the beat for 50: it is not counted and 10 never appears
        addRow(1, 0, 1, v4, 1, 1, 0, 1, 0, 0, 0, 1);
        beatRow(1, 100, 0, 0);
        addRow(1, 1, 0, '0, 1, 0, 1, 1, 50, 0, 0, 1);
        idleRow(1);
        idleRow(1);
        // Flush in IDLE beats a simultaneous in_valid
        addRow(1, 1, 1, v1, 1, 1, 0, 1, 0, 0, 0, 1);
        idleRow(1);
        // Reset mid-transaction wins over flush and out_ready
        addRow(1, 0, 1, v2, 1, 1, 0, 1, 0, 0, 0, 1);
        beatRow(1, 200, 0, 0);
        addRow(0, 1, 1, v1, 1, 0, 0, 0, 0, 0, 0, 1);
        idleRow(0);

        // Reset held for three cycles with in_valid high
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_vector = v1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset%0d in_ready", c), CAM_LEN'(in_ready), '0);
            check($sformatf("reset%0d out_valid", c), CAM_LEN'(out_valid), '0);
            check($sformatf("reset%0d beat_cnt", c), CAM_LEN'(beat_cnt), '0);
        end

        foreach (rows[r]) begin
            rst_n = rows[r].rstN; flush = rows[r].flush; in_valid = rows[r].inValid;
            in_vector = rows[r].vec; out_ready = rows[r].outReady;
            #1;
            check($sformatf("row%0d in_ready", r), CAM_LEN'(in_ready), CAM_LEN'(rows[r].expReady));
            check($sformatf("row%0d out_valid", r), CAM_LEN'(out_valid), CAM_LEN'(rows[r].expValid));
            check($sformatf("row%0d beat_cnt", r), CAM_LEN'(beat_cnt), CAM_LEN'(rows[r].expCnt));
            if (rows[r].chkData) begin
                exp1h = '0;
                if (rows[r].expValid && !rows[r].expNone) exp1h[rows[r].expIdx] = 1'b1;
                check($sformatf("row%0d out_index", r), CAM_LEN'(out_index), CAM_LEN'(rows[r].expIdx));
                check($sformatf("row%0d out_none", r), CAM_LEN'(out_none), CAM_LEN'(rows[r].expNone));
                check($sformatf("row%0d out_last", r), CAM_LEN'(out_last), CAM_LEN'(rows[r].expLast));
                check($sformatf("row%0d out_onehot", r), out_onehot, exp1h);
            end
            @(negedge clk);
        end

        // Full vector: 256 beats, 255 down to 0
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; in_vector = allOnes; out_ready = 1'b1;
        #1;
        check("full accept in_ready", CAM_LEN'(in_ready), CAM_LEN'(1));
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = CAM_LEN - 1; i >= 0; i--) begin
            #1;
            exp1h = '0;
            exp1h[i] = 1'b1;
            check($sformatf("full%0d out_index", i), CAM_LEN'(out_index), CAM_LEN'(i));
            check($sformatf("full%0d out_onehot", i), out_onehot, exp1h);
            check($sformatf("full%0d out_last", i), CAM_LEN'(out_last), CAM_LEN'(i == 0));
            check($sformatf("full%0d beat_cnt", i), CAM_LEN'(beat_cnt), CAM_LEN'(CAM_LEN - 1 - i));
            @(negedge clk);
        end
        #1;
        check("full done in_ready", CAM_LEN'(in_ready), CAM_LEN'(1));
        check("full done out_valid", CAM_LEN'(out_valid), '0);
        check("full done beat_cnt", CAM_LEN'(beat_cnt), CAM_LEN'(256));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
